conv_window_sequencer: RTL and testbench
========================================

// Module: conv_window_sequencer
// PURPOSE
// - Sequences a single-MAC float32 convolution datapath over an IMG_H x IMG_W image with a K x K filter (valid mode, stride 1).
// - Per output pixel, walks the K*K taps in row-major order and emits image and filter coordinates to the MAC.
// - Tracks results through the MAC pipeline and emits output-buffer write strobes with coordinates.
// - Sits between the layer-level start logic and the Conv1F-style MAC/accumulator and its 28x28 output buffer.
// PARAMETERS
// - IMG_H    32  image rows
// - IMG_W    32  image columns
// - K        5   filter side; OUT_H = IMG_H-K+1, OUT_W = IMG_W-K+1 (28x28 by default)
// - MAC_LAT  4   cycles from acceptance of a window's last tap to its result being valid (>=1)
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   asynchronous reset, active-high
// - start      in   1   begin one full convolution; sampled only in IDLE
// - busy       out  1   high in RUN and DRAIN
// - done       out  1   one-cycle pulse on completion
// - mac_valid  out  1   tap coordinates valid
// - mac_ready  in   1   MAC accepts the tap (transfer = mac_valid & mac_ready)
// - mac_first  out  1   tap (0,0) of a window: accumulator clears
// - mac_last   out  1   tap (K-1,K-1) of a window
// - img_row    out  $clog2(IMG_H)  image row = out_r + kr
// - img_col    out  $clog2(IMG_W)  image column = out_c + kc
// - flt_row    out  $clog2(K)      filter row kr
// - flt_col    out  $clog2(K)      filter column kc
// - out_we     out  1   write result to output buffer
// - out_row    out  $clog2(OUT_H)  output row for out_we
// - out_col    out  $clog2(OUT_W)  output column for out_we
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; all counters 0; delay line cleared. A reset mid-run aborts immediately, and no out_we/done follows.
// - FSM IDLE->RUN on start; RUN->DRAIN on transfer of last tap of window (OUT_H-1,OUT_W-1); DRAIN->DONE when the delay line is empty; DONE->IDLE after 1 cycle (done=1).
// - start in RUN/DRAIN/DONE is ignored; there is no queuing.
// - RUN: mac_valid=1 every cycle. Coordinates and first/last flags hold stable while mac_ready=0.
// - On each transfer: kc++. At kc=K-1, kc wraps to 0 and kr++. At kr=K-1, kr wraps and out_c++. At out_c=OUT_W-1, out_c wraps and out_r++.
// - mac_first/mac_last are combinational from kr,kc and are gated by mac_valid.
// - Delay line: MAC_LAT-stage shift register of {vld,out_r,out_c}, loaded with the window coordinates on a mac_last transfer and advanced every cycle (independent of mac_ready).
// - out_we is asserted exactly MAC_LAT cycles after the mac_last transfer, with the matching out_row/out_col.
// - All counters are unsigned and sized to hold the max index; there is no overflow path. Image indices never exceed IMG-1.
// - Timing with mac_ready=1: start sampled at edge 0; mac_valid during cycles 1..N where N = OUT_H*OUT_W*K*K (19600 by default).
//   Last out_we in cycle N+MAC_LAT; done in cycle N+MAC_LAT+1.
// CONFIGURATION
// - CONV_SEQ_PERF_EN defined: extra port stall_cnt out 32. It counts RUN cycles with mac_valid & ~mac_ready, clears on start acceptance, and saturates at 2^32-1. It holds its value after done and is 0 at reset.
// - CONV_SEQ_PERF_EN undefined: the port and counter are absent; behaviour is otherwise identical.
// TESTING
// - Reset: assert rst mid-cycle -> busy=done=mac_valid=out_we=0 and all coordinates 0 without waiting for a clock edge.
// - Full run, defaults, mac_ready=1: 19600 transfers and 784 out_we in raster order. First out_we (0,0) in cycle 29, last (27,27) in cycle 19604, done in cycle 19605.
// - Boundary: window (0,27) tap (4,4) -> img_row=4, img_col=31. The next transfer is window (1,0) tap (0,0) with mac_first=1, img_row=1, img_col=0.
// - Backpressure: mac_ready pseudo-random at 50% -> coordinates are stable across stalls, out_we count stays 784, and stall_cnt equals the number of stalled cycles (PERF_EN build).
// - start pulsed during RUN and during DRAIN -> no effect; exactly one done, with 784 writes.
// - rst asserted at cycle 1000, then start -> no stray out_we from the aborted run; the new run completes with 784 writes and done in cycle 19605 after the new start.

Source files
------------

// File: rtl/conv_window_sequencer_if.sv
// Tap-address and output-write bundle between conv_window_sequencer and its MAC/output buffer.
// CONV_SEQ_PERF_EN adds the stall_cnt performance counter to the bundle.
interface conv_window_sequencer_if #(
  parameter int IMG_H = 32,
  parameter int IMG_W = 32,
  parameter int K     = 5
);
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int IRW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ICW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int KW    = (K > 1)     ? $clog2(K)     : 1;
  localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic           start;
  logic           busy;
  logic           done;
  logic           mac_valid;
  logic           mac_ready;
  logic           mac_first;
  logic           mac_last;
  logic [IRW-1:0] img_row;
  logic [ICW-1:0] img_col;
  logic [KW-1:0]  flt_row;
  logic [KW-1:0]  flt_col;
  logic           out_we;
  logic [ORW-1:0] out_row;
  logic [OCW-1:0] out_col;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]    stall_cnt;

  modport master (
    input  start, mac_ready,
    output busy, done, mac_valid, mac_first, mac_last,
           img_row, img_col, flt_row, flt_col,
           out_we, out_row, out_col, stall_cnt
  );
  modport slave (
    output start, mac_ready,
    input  busy, done, mac_valid, mac_first, mac_last,
           img_row, img_col, flt_row, flt_col,
           out_we, out_row, out_col, stall_cnt
  );
`else
  modport master (
    input  start, mac_ready,
    output busy, done, mac_valid, mac_first, mac_last,
           img_row, img_col, flt_row, flt_col,
           out_we, out_row, out_col
  );
  modport slave (
    output start, mac_ready,
    input  busy, done, mac_valid, mac_first, mac_last,
           img_row, img_col, flt_row, flt_col,
           out_we, out_row, out_col
  );
`endif
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks every K x K window of a valid-mode stride-1 convolution, feeding tap coordinates to a single MAC
// and issuing output-buffer writes MAC_LAT cycles after each window's last tap. Optional: CONV_SEQ_PERF_EN.
module conv_window_sequencer #(
  parameter int IMG_H   = 32,
  parameter int IMG_W   = 32,
  parameter int K       = 5,
  parameter int MAC_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_window_sequencer_if.master bus
);
  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int IRW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ICW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int KW    = (K > 1)     ? $clog2(K)     : 1;
  localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);
  localparam logic [ORW-1:0] OR_MAX = ORW'(OUT_H - 1);
  localparam logic [OCW-1:0] OC_MAX = OCW'(OUT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state;
  logic           busy_q;
  logic           done_q;
  logic           valid_q;
  logic [KW-1:0]  kr;
  logic [KW-1:0]  kc;
  logic [ORW-1:0] out_r;
  logic [OCW-1:0] out_c;

  logic           dl_vld [MAC_LAT];
  logic [ORW-1:0] dl_r   [MAC_LAT];
  logic [OCW-1:0] dl_c   [MAC_LAT];

  logic transfer;
  logic tap_first;
  logic tap_last;
  logic win_last;
  logic drain_empty;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] stall_q;
`endif

  always_comb begin
    transfer  = valid_q & bus.mac_ready;
    tap_first = (kr == '0) && (kc == '0);
    tap_last  = (kr == K_MAX) && (kc == K_MAX);
    win_last  = tap_last && (out_r == OR_MAX) && (out_c == OC_MAX);
    // The last stage is retiring this cycle, so only the earlier stages decide whether anything is still in flight.
    drain_empty = 1'b1;
    for (int unsigned i = 0; i + 1 < MAC_LAT; i++) begin
      if (dl_vld[i]) drain_empty = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      kr      <= '0;
      kc      <= '0;
      out_r   <= '0;
      out_c   <= '0;
      for (int unsigned i = 0; i < MAC_LAT; i++) begin
        dl_vld[i] <= 1'b0;
        dl_r[i]   <= '0;
        dl_c[i]   <= '0;
      end
`ifdef CONV_SEQ_PERF_EN
      stall_q <= '0;
`endif
    end else begin
      dl_vld[0] <= transfer & tap_last;
      dl_r[0]   <= out_r;
      dl_c[0]   <= out_c;
      for (int unsigned i = 1; i < MAC_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_r[i]   <= dl_r[i-1];
        dl_c[i]   <= dl_c[i-1];
      end

      if (transfer) begin
        if (kc == K_MAX) begin
          kc <= '0;
          if (kr == K_MAX) begin
            kr <= '0;
            if (out_c == OC_MAX) begin
              out_c <= '0;
              out_r <= (out_r == OR_MAX) ? '0 : out_r + 1'b1;
            end else begin
              out_c <= out_c + 1'b1;
            end
          end else begin
            kr <= kr + 1'b1;
          end
        end else begin
          kc <= kc + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            kr      <= '0;
            kc      <= '0;
            out_r   <= '0;
            out_c   <= '0;
`ifdef CONV_SEQ_PERF_EN
            stall_q <= '0;
`endif
          end
        end
        S_RUN: begin
`ifdef CONV_SEQ_PERF_EN
          if (valid_q && !bus.mac_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
`endif
          if (transfer && win_last) begin
            state   <= S_DRAIN;
            valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_empty) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mac_valid = valid_q;
  assign bus.mac_first = valid_q & tap_first;
  assign bus.mac_last  = valid_q & tap_last;
  assign bus.img_row   = IRW'(out_r) + IRW'(kr);
  assign bus.img_col   = ICW'(out_c) + ICW'(kc);
  assign bus.flt_row   = kr;
  assign bus.flt_col   = kc;
  assign bus.out_we    = dl_vld[MAC_LAT-1];
  assign bus.out_row   = dl_r[MAC_LAT-1];
  assign bus.out_col   = dl_c[MAC_LAT-1];
`ifdef CONV_SEQ_PERF_EN
  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: timeline model of transfers and scheduled writes, checked every cycle,
// plus literal pins for the 28x28 default geometry. Covers CONV_SEQ_PERF_EN when defined.
module tb_conv_window_sequencer;
  localparam int IMG_H   = 32;
  localparam int IMG_W   = 32;
  localparam int K       = 5;
  localparam int MAC_LAT = 4;
  localparam int OH      = IMG_H - K + 1;
  localparam int OW      = IMG_W - K + 1;
  localparam int KK      = K * K;
  localparam int N       = OH * OW * KK;

  logic clk;
  logic rst;

  conv_window_sequencer_if #(.IMG_H(IMG_H), .IMG_W(IMG_W), .K(K)) bus ();

  conv_window_sequencer #(.IMG_H(IMG_H), .IMG_W(IMG_W), .K(K), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: what the outputs must be in the cycle following each edge.
  int unsigned ecount = 0, start_edge = 0, cyc_now = 0;
  int unsigned m_t = 0, m_row = 0, m_col = 0, m_stalls = 0, m_done_edge = 0;
  bit          m_busy = 0, m_done = 0, m_valid = 0, m_we = 0, m_pend = 0, accept;
  int unsigned due_q[$], r_q[$], c_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_valid = 0; m_we = 0; m_pend = 0;
      m_t = 0; m_row = 0; m_col = 0; m_stalls = 0;
      due_q.delete(); r_q.delete(); c_q.delete();
    end else begin
      accept = bus.start && !m_busy && !m_done;
      if (m_valid) begin
        if (bus.mac_ready) begin
          if (m_t % KK == KK - 1) begin
            due_q.push_back(ecount + MAC_LAT - 1);
            r_q.push_back((m_t / KK) / OW);
            c_q.push_back((m_t / KK) % OW);
          end
          m_t++;
          if (m_t == N) begin
            m_valid = 0;
            m_pend = 1;
            m_done_edge = ecount + MAC_LAT;
          end
        end else begin
          m_stalls++;
        end
      end
      m_we = 0;
      if (due_q.size() > 0 && due_q[0] == ecount) begin
        m_we = 1;
        m_row = r_q.pop_front();
        m_col = c_q.pop_front();
        void'(due_q.pop_front());
      end
      m_done = 0;
      if (m_pend && ecount == m_done_edge) begin
        m_done = 1; m_busy = 0; m_pend = 0;
      end
      if (accept) begin
        m_busy = 1; m_valid = 1; m_t = 0; m_stalls = 0; start_edge = ecount;
      end
      cyc_now = ecount - start_edge + 1;
      ecount++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit          timed_run = 0;
  int unsigned we_seen = 0, first_we_cyc = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mac_valid", bus.mac_valid, 0);
      chk("rst_out_we", bus.out_we, 0);
      chk("rst_img_row", bus.img_row, 0);
      chk("rst_img_col", bus.img_col, 0);
      chk("rst_flt_row", bus.flt_row, 0);
      chk("rst_flt_col", bus.flt_col, 0);
      chk("rst_out_row", bus.out_row, 0);
      chk("rst_out_col", bus.out_col, 0);
`ifdef CONV_SEQ_PERF_EN
      chk("rst_stall_cnt", bus.stall_cnt, 0);
`endif
    end else begin
      int unsigned win, tap;
      win = m_t / KK;
      tap = m_t % KK;
      if (m_busy && cyc_now == 1) begin
        we_seen = 0;
        first_we_cyc = 0;
      end
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("mac_valid", bus.mac_valid, m_valid);
      chk("mac_first", bus.mac_first, m_valid && tap == 0);
      chk("mac_last", bus.mac_last, m_valid && tap == KK - 1);
      if (m_valid) begin
        chk("img_row", bus.img_row, win / OW + tap / K);
        chk("img_col", bus.img_col, win % OW + tap % K);
        chk("flt_row", bus.flt_row, tap / K);
        chk("flt_col", bus.flt_col, tap % K);
        if (m_t == 27 * KK + KK - 1) begin
          chk("edge_img_row", bus.img_row, 4);
          chk("edge_img_col", bus.img_col, 31);
        end
        if (m_t == 28 * KK) begin
          chk("wrap_first", bus.mac_first, 1);
          chk("wrap_img_row", bus.img_row, 1);
          chk("wrap_img_col", bus.img_col, 0);
        end
      end
      chk("out_we", bus.out_we, m_we);
      if (m_we) begin
        chk("out_row", bus.out_row, m_row);
        chk("out_col", bus.out_col, m_col);
      end
`ifdef CONV_SEQ_PERF_EN
      chk("stall_cnt", bus.stall_cnt, m_stalls);
`endif
      if (bus.out_we) begin
        we_seen++;
        if (first_we_cyc == 0) first_we_cyc = cyc_now;
      end
      if (bus.done) begin
        chk("run_writes", we_seen, 784);
        chk("model_transfers", m_t, 19600);
        if (timed_run) begin
          chk("first_we_cycle", first_we_cyc, 29);
          chk("done_cycle", cyc_now, 19605);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, input int unsigned limit);
    int unsigned n = 0;
    while (!m_done) begin
      @(negedge clk);
      if (rnd) bus.mac_ready = ($urandom_range(0, 1) == 1);
      n++;
      if (n > limit) begin
        $display("FAIL run_timeout: actual=%0d cycles required<=%0d", n, limit);
        $fatal(1, "run did not complete");
      end
    end
    bus.mac_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mac_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full run with extra start pulses in RUN and in DRAIN.
    timed_run = 1;
    pulse_start();
    repeat (5000) @(negedge clk);
    pulse_start();
    n = 0;
    while (m_valid) begin
      @(negedge clk);
      n++;
      if (n > 25000) begin
        $display("FAIL drain_wait: actual=%0d cycles required<=25000", n);
        $fatal(1, "drain not reached");
      end
    end
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    run_until_done(0, 100);

    // Abort near cycle 1000 with a mid-cycle reset, then a clean run.
    pulse_start();
    repeat (998) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start();
    run_until_done(0, 25000);

    // Pseudo-random backpressure.
    timed_run = 0;
    pulse_start();
    run_until_done(1, 60000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
